// File: rtl/anc_pkg.sv
// Shared types and widths for the ANC frame sequencer.
package anc_pkg;
  localparam int SAMPLE_W = 32;
  localparam int MU_W     = 16;
  localparam int PROD_W   = SAMPLE_W + MU_W;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    GO   = 3'd2,
    WAIT = 3'd3,
    OUT  = 3'd4
  } state_e;
endpackage

// File: rtl/anc_sat_shift.sv
// Combinational arithmetic right shift followed by signed saturation to OUT_W.
module anc_sat_shift #(
  parameter int IN_W  = 48,
  parameter int SHIFT = 0,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  d_i,
  output logic [OUT_W-1:0] q_o
);
  logic signed [IN_W-1:0] sh;

  assign sh = $signed(d_i) >>> SHIFT;

  generate
    if (OUT_W >= IN_W) begin : g_ext
      // Output is wide enough: plain sign extension, never clips.
      assign q_o = OUT_W'(sh);
    end else begin : g_sat
      // Value fits iff all bits from the OUT_W sign bit upward agree.
      logic [IN_W-OUT_W:0] hi;
      logic                ovf;
      assign hi  = sh[IN_W-1:OUT_W-1];
      assign ovf = !((&hi) || !(|hi));
      assign q_o = !ovf        ? sh[OUT_W-1:0] :
                   sh[IN_W-1]  ? {1'b1, {(OUT_W-1){1'b0}}} :
                                 {1'b0, {(OUT_W-1){1'b1}}};
    end
  endgenerate
endmodule

// File: rtl/anc_frame_sequencer.sv
// Per-frame sequencer in front of the adaptive FIR: LMS update, go/done
// handshake with watchdog, and anti-noise output scaling/saturation.
module anc_frame_sequencer
  import anc_pkg::*;
#(
  parameter int MU_SHIFT    = 15,
  parameter int OUT_SHIFT   = 0,
  parameter int OUT_W       = 16,
  parameter int INVERT      = 1,
  parameter int TIMEOUT_CYC = 300
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] ref_in,
  input  logic [SAMPLE_W-1:0] err_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MU_W-1:0]     mu,
  output logic [SAMPLE_W-1:0] fir_feedforward,
  output logic [SAMPLE_W-1:0] fir_weight_adjust,
  output logic                fir_go,
  input  logic                fir_done,
  input  logic [SAMPLE_W-1:0] fir_out_sample,
  output logic [OUT_W-1:0]    anti_out,
  output logic                anti_valid,
  output logic                busy,
  output logic                overrun_err,
  output logic                timeout_err,
  input  logic                err_clr
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC - 1);

  state_e                     state_q;
  logic signed [SAMPLE_W-1:0] err_q;
  logic signed [MU_W-1:0]     mu_q;
  logic [CNT_W-1:0]           cnt_q;

  logic signed [PROD_W-1:0]   prod;
  logic [SAMPLE_W-1:0]        wadj_d;
  logic [SAMPLE_W-1:0]        cap_d;
  logic signed [SAMPLE_W-1:0] cap_sh;
  logic signed [SAMPLE_W:0]   v_d;
  logic [OUT_W-1:0]           anti_d;

  assign prod = err_q * mu_q;

  anc_sat_shift #(.IN_W(PROD_W), .SHIFT(MU_SHIFT), .OUT_W(SAMPLE_W)) u_wsat (
    .d_i(prod),
    .q_o(wadj_d)
  );

  // The output path is evaluated on the sample being captured, so anti_out
  // and anti_valid appear together in the OUT cycle. A timeout captures 0.
  assign cap_d  = fir_done ? fir_out_sample : '0;
  assign cap_sh = $signed(cap_d) >>> OUT_SHIFT;
  // Negate at 33 bits so that -(-2^31) is representable before clamping.
  assign v_d    = (INVERT != 0) ? -{cap_sh[SAMPLE_W-1], cap_sh}
                                :  {cap_sh[SAMPLE_W-1], cap_sh};

  anc_sat_shift #(.IN_W(SAMPLE_W + 1), .SHIFT(0), .OUT_W(OUT_W)) u_osat (
    .d_i(v_d),
    .q_o(anti_d)
  );

  // Frame FSM with registered outputs, watchdog counter and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      err_q             <= '0;
      mu_q              <= '0;
      cnt_q             <= '0;
      fir_feedforward   <= '0;
      fir_weight_adjust <= '0;
      fir_go            <= 1'b0;
      anti_out          <= '0;
      anti_valid        <= 1'b0;
      busy              <= 1'b0;
      in_ready          <= 1'b1;
      overrun_err       <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      // Clear first so a same-cycle set below takes priority.
      if (err_clr) begin
        overrun_err <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (in_valid && !in_ready) overrun_err <= 1'b1;

      case (state_q)
        IDLE: begin
          if (in_valid) begin
            fir_feedforward <= ref_in;
            err_q           <= err_in;
            mu_q            <= mu;
            in_ready        <= 1'b0;
            busy            <= 1'b1;
            state_q         <= CALC;
          end
        end
        CALC: begin
          fir_weight_adjust <= wadj_d;
          fir_go            <= 1'b1;
          state_q           <= GO;
        end
        GO: begin
          fir_go  <= 1'b0;
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (fir_done || cnt_q == CNT_LIM) begin
            if (!fir_done) timeout_err <= 1'b1;
            anti_out   <= anti_d;
            anti_valid <= 1'b1;
            state_q    <= OUT;
          end
        end
        OUT: begin
          anti_valid <= 1'b0;
          busy       <= 1'b0;
          in_ready   <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          fir_go     <= 1'b0;
          anti_valid <= 1'b0;
          busy       <= 1'b0;
          in_ready   <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_anc_frame_sequencer.sv
// Scoreboard bench: frames push expected go/anti events, monitors pop and check.
module tb_anc_frame_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ref_in = '0, err_in = '0, fir_out_sample = '0;
  logic [15:0] mu = '0;
  logic        in_valid = 1'b0, fir_done = 1'b0, err_clr = 1'b0;

  logic        in_ready, fir_go, anti_valid, busy, overrun_err, timeout_err;
  logic [31:0] fir_feedforward, fir_weight_adjust;
  logic [15:0] anti_out;
  logic        b_in_ready, b_fir_go, b_anti_valid, b_busy, b_overrun_err, b_timeout_err;
  logic [31:0] b_fir_feedforward, b_fir_weight_adjust;
  logic [15:0] b_anti_out;

  always #5 clk = ~clk;

  anc_frame_sequencer u_a (
    .clk(clk), .rst_n(rst_n), .ref_in(ref_in), .err_in(err_in), .in_valid(in_valid),
    .in_ready(in_ready), .mu(mu), .fir_feedforward(fir_feedforward),
    .fir_weight_adjust(fir_weight_adjust), .fir_go(fir_go), .fir_done(fir_done),
    .fir_out_sample(fir_out_sample), .anti_out(anti_out), .anti_valid(anti_valid),
    .busy(busy), .overrun_err(overrun_err), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  anc_frame_sequencer #(.MU_SHIFT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .ref_in(ref_in), .err_in(err_in), .in_valid(in_valid),
    .in_ready(b_in_ready), .mu(mu), .fir_feedforward(b_fir_feedforward),
    .fir_weight_adjust(b_fir_weight_adjust), .fir_go(b_fir_go), .fir_done(fir_done),
    .fir_out_sample(fir_out_sample), .anti_out(b_anti_out), .anti_valid(b_anti_valid),
    .busy(b_busy), .overrun_err(b_overrun_err), .timeout_err(b_timeout_err), .err_clr(err_clr)
  );

  typedef struct { logic [31:0] ff; logic [31:0] wa_a; logic [31:0] wa_b; } go_t;
  typedef struct { logic [15:0] anti; int lat; } an_t;

  go_t go_q[$];
  an_t an_q[$];
  int  total = 0, bad = 0;
  int  cyc = 0, go_cyc = 0, go_seen = 0, go_exp = 0;
  int  stub_dly = -1;
  logic [31:0] stub_smp = '0, last_wa = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // FIR stub: done pulse stub_dly cycles after the go cycle, or never if negative.
  initial begin
    forever begin
      @(negedge clk);
      if (fir_go && rst_n) begin
        int d;
        d = stub_dly;
        if (d >= 0) begin
          repeat (d) @(negedge clk);
          fir_out_sample = stub_smp;
          fir_done = 1'b1;
          @(negedge clk);
          fir_done = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents fir_go or anti_valid.
  initial begin
    forever begin
      @(negedge clk);
      if (fir_go) begin
        go_seen++;
        go_cyc = cyc;
        chk("go_pair", {31'd0, b_fir_go}, 32'd1);
        if (go_q.size() == 0) chk("unexpected_go", 32'd1, 32'd0);
        else begin
          go_t g;
          g = go_q.pop_front();
          chk("feedforward", fir_feedforward, g.ff);
          chk("weight_adj", fir_weight_adjust, g.wa_a);
          chk("weight_adj_shift0", b_fir_weight_adjust, g.wa_b);
          last_wa = g.wa_a;
        end
      end
      if (anti_valid) begin
        if (an_q.size() == 0) chk("unexpected_anti", 32'd1, 32'd0);
        else begin
          an_t a;
          a = an_q.pop_front();
          chk("anti_out", {16'd0, anti_out}, {16'd0, a.anti});
          chk("anti_latency", cyc - go_cyc, a.lat);
          chk("weight_hold", fir_weight_adjust, last_wa);
        end
      end
    end
  end

  task automatic start_frame(input logic [31:0] r, input logic [31:0] e, input logic [15:0] m,
                             input int dly, input logic [31:0] smp,
                             input logic [31:0] wa_a, input logic [31:0] wa_b,
                             input logic [15:0] anti, input bit push_anti);
    go_t g;
    an_t a;
    g.ff = r; g.wa_a = wa_a; g.wa_b = wa_b;
    go_q.push_back(g);
    go_exp++;
    if (push_anti) begin
      a.anti = anti; a.lat = (dly < 0) ? 301 : dly + 1;
      an_q.push_back(a);
    end
    stub_dly = dly;
    stub_smp = smp;
    ref_in = r; err_in = e; mu = m; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ff"}, fir_feedforward, 32'd0);
    chk({tag, "_wa"}, fir_weight_adjust, 32'd0);
    chk({tag, "_go"}, {31'd0, fir_go}, 32'd0);
    chk({tag, "_anti"}, {16'd0, anti_out}, 32'd0);
    chk({tag, "_avld"}, {31'd0, anti_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_ovr"}, {31'd0, overrun_err}, 32'd0);
    chk({tag, "_tmo"}, {31'd0, timeout_err}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal: 1000*0x4000>>>15 = 500; -1234 = 0xFB2E.
    start_frame(32'd7, 32'd1000, 16'h4000, 6, 32'd1234, 32'd500, 32'd16384000, 16'hFB2E, 1);
    wait_idle();
    // Positive clip of update (u_b) and of output: -0x12345 -> 0x8000.
    start_frame(32'h11111111, 32'h7FFFFFFF, 16'h7FFF, 3, 32'h00012345,
                32'h7FFEFFFF, 32'h7FFFFFFF, 16'h8000, 1);
    wait_idle();
    // Negative clip of update; -(-2^31) clips to 0x7FFF.
    start_frame(32'hDEADBEEF, 32'h80000000, 16'h7FFF, 10, 32'h80000000,
                32'h80010000, 32'h80000000, 16'h7FFF, 1);
    wait_idle();
    // Timeout: no done, OUT 301 cycles after go with 0.
    start_frame(32'h0BADF00D, 32'hFFFFFC18, 16'h4000, -1, 32'd0,
                32'hFFFFFE0C, 32'hFF060000, 16'h0000, 1);
    wait_idle();
    chk("timeout_set", {31'd0, timeout_err}, 32'd1);
    chk("timeout_set_b", {31'd0, b_timeout_err}, 32'd1);
    repeat (3) @(negedge clk);
    chk("timeout_sticky", {31'd0, timeout_err}, 32'd1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("timeout_clr", {31'd0, timeout_err}, 32'd0);
    // Done on the last WAIT cycle wins over the watchdog.
    start_frame(32'd42, 32'd0, 16'h0000, 300, 32'hFFFFFFFB, 32'd0, 32'd0, 16'h0005, 1);
    wait_idle();
    chk("limit_no_timeout", {31'd0, timeout_err}, 32'd0);
    // Overrun during WAIT, coincident with err_clr: set wins, frame dropped.
    start_frame(32'd9, 32'd1000, 16'h4000, 20, 32'd100, 32'd500, 32'd16384000, 16'hFF9C, 1);
    repeat (4) @(negedge clk);
    ref_in = 32'hFFFFFFFF; in_valid = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; err_clr = 1'b0;
    chk("overrun_set", {31'd0, overrun_err}, 32'd1);
    wait_idle();
    chk("overrun_sticky", {31'd0, overrun_err}, 32'd1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("overrun_clr", {31'd0, overrun_err}, 32'd0);
    // Reset in WAIT: immediate reset values, no anti_valid for this frame.
    start_frame(32'd5, 32'd2000, 16'h4000, 20, 32'd77, 32'd1000, 32'h01F40000, 16'h0000, 0);
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    // Normal frame after the aborted one; -1 = 0xFFFF.
    start_frame(32'd3, 32'd2000, 16'h4000, 6, 32'd1, 32'd1000, 32'h01F40000, 16'hFFFF, 1);
    wait_idle();

    chk("go_queue_empty", go_q.size(), 32'd0);
    chk("anti_queue_empty", an_q.size(), 32'd0);
    chk("go_count", go_seen, go_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
